// File: rtl/reconfig_pkg.sv
// reconfig_pkg: shared definitions for the MultiBoot reconfiguration request
// front end.
//   state_e          FSM state encoding
//   DEFAULT_KEY1/2   default unlock byte values
//   STATUS_*         bit positions inside the status byte
package reconfig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEY1  = 3'd1,
    ST_KEY2  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_PULSE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic [7:0] DEFAULT_KEY1 = 8'hA5;
  localparam logic [7:0] DEFAULT_KEY2 = 8'h5A;

  localparam int STATUS_BUSY   = 7;
  localparam int STATUS_ERR    = 6;
  localparam int STATUS_DONE   = 5;
  localparam int STATUS_DN_MSB = 4;

endpackage

// File: rtl/reconfig_timer.sv
// reconfig_timer: loadable down-counter that saturates at zero.
//   fastclk   in          clock
//   rst_n     in          async active-low reset (count clears to 0)
//   load      in          load load_val (wins over en)
//   en        in          decrement by one when count is non-zero
//   load_val  in  WIDTH   value to load
//   zero      out         terminal count reached (count == 0)
module reconfig_timer #(
  parameter int WIDTH = 11
) (
  input  logic             fastclk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !zero) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/reconfig_request.sv
// reconfig_request: host-facing unlock/GO front end that drives design_num and
// a stretched reconfigure pulse into the ICAP sequencer.
//   fastclk      in      clock
//   rst_n        in      async active-low reset
//   wr_en        in      single-cycle write strobe
//   wr_data      in  8   write byte
//   design_num   out 5   selected design image
//   reconfigure  out 1   reconfiguration request (high only in PULSE)
//   busy         out 1   high in HOLD, PULSE, DONE
//   err          out 1   sticky error flag
//   status       out 8   {busy, err, done, design_num}
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for first unlock byte; 0x00 clears err
// ST_KEY1  | first key seen, waiting for second key (timeout armed)
// ST_KEY2  | both keys seen, waiting for GO byte (timeout armed)
// ST_HOLD  | design_num stable, counting holdoff before the pulse
// ST_PULSE | reconfigure asserted
// ST_DONE  | terminal; FPGA reboots, only reset leaves
module reconfig_request
  import reconfig_pkg::*;
#(
  parameter logic [7:0]  KEY1           = DEFAULT_KEY1,
  parameter logic [7:0]  KEY2           = DEFAULT_KEY2,
  parameter logic [31:0] VALID_MASK     = 32'h0001_FF9F,
  parameter logic [4:0]  DEFAULT_DESIGN = 5'b10000,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          HOLDOFF_CYCLES = 8,
  parameter int          PULSE_CYCLES   = 4   // >= 2: consumer samples on fastclk/2
) (
  input  logic       fastclk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic [4:0] design_num,
  output logic       reconfigure,
  output logic       busy,
  output logic       err,
  output logic [7:0] status
);

  localparam int TMAX = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ? TIMEOUT_CYCLES : HOLDOFF_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  state_e        state;
  logic          done;
  logic          tmr_load;
  logic          tmr_en;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;
  logic          go_ok;

  assign go_ok = wr_data[7] && (wr_data[6:5] == 2'b00) && VALID_MASK[wr_data[4:0]];

  // The timer loads on the edge that enters a counted state, so HOLD loads the
  // full holdoff (transition happens on the edge after it hits zero) while
  // PULSE loads one less (its entry edge is already the first pulse cycle).
  always_comb begin
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: begin
        if (wr_en) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(TIMEOUT_CYCLES);
        end
      end
      ST_KEY1: begin
        if (wr_en) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(TIMEOUT_CYCLES);
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_KEY2: begin
        if (wr_en) begin
          tmr_load = 1'b1;
          tmr_val  = go_ok ? TW'(HOLDOFF_CYCLES) : TW'(TIMEOUT_CYCLES);
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(PULSE_CYCLES - 1);
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_PULSE: tmr_en = 1'b1;
      default: ;
    endcase
  end

  reconfig_timer #(.WIDTH(TW)) u_timer (
    .fastclk  (fastclk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // A write in the expiry cycle is checked first, so it wins over the timeout.
  always_ff @(posedge fastclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      design_num  <= DEFAULT_DESIGN;
      reconfigure <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_en) begin
            if (wr_data == KEY1) begin
              state <= ST_KEY1;
              err   <= 1'b0;
            end else if (wr_data == 8'h00) begin
              err <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_KEY1: begin
          if (wr_en) begin
            if (wr_data == KEY2) begin
              state <= ST_KEY2;
            end else begin
              state <= ST_IDLE;
              err   <= 1'b1;
            end
          end else if (tmr_zero) begin
            state <= ST_IDLE;
            err   <= 1'b1;
          end
        end
        ST_KEY2: begin
          if (wr_en) begin
            if (go_ok) begin
              state      <= ST_HOLD;
              design_num <= wr_data[4:0];
              busy       <= 1'b1;
            end else begin
              state <= ST_IDLE;
              err   <= 1'b1;
            end
          end else if (tmr_zero) begin
            state <= ST_IDLE;
            err   <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (tmr_zero) begin
            state       <= ST_PULSE;
            reconfigure <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (tmr_zero) begin
            state       <= ST_DONE;
            reconfigure <= 1'b0;
            done        <= 1'b1;
          end
        end
        ST_DONE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    status                   = '0;
    status[STATUS_BUSY]      = busy;
    status[STATUS_ERR]       = err;
    status[STATUS_DONE]      = done;
    status[STATUS_DN_MSB:0]  = design_num;
  end

endmodule
